// File: rtl/pin_state_streamer.sv
// Snapshots pin_state on start and streams SYNC_BYTE, NUM_BYTES data bytes and an XOR checksum.
// The first byte is valid the cycle after start. tx_ready=0 holds the byte indefinitely; a start while busy is dropped.
module pin_state_streamer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          NUM_BYTES      = 17,
  // frame_cnt value after reset; leave at zero outside of counter-wrap testing
  parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
  input  logic        CLK50,
  input  logic        RST_N,
  input  logic        start,
  input  logic [7:0]  pin_state [0:NUM_BYTES-1],
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        dropped,
  output logic [15:0] frame_cnt
);

  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    shadow [0:NUM_BYTES-1];
  logic [IW-1:0] idx;
  logic [7:0]    csum;

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // tx_data/tx_valid are decoded from state so that reset clears them immediately
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = shadow[idx];
        if (tx_ready && (idx == LAST_IDX)) begin
          state_nxt = CSUM;
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CLK50 or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow[i] <= 8'h00;
      end
      idx       <= '0;
      csum      <= 8'h00;
      done      <= 1'b0;
      dropped   <= 1'b0;
      frame_cnt <= FRAME_CNT_INIT;
    end else begin
      done    <= (state == CSUM) && tx_ready;
      dropped <= start && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= pin_state;
            csum   <= 8'h00;
            idx    <= '0;
          end
        end
        SYNC: begin
          if (tx_ready) begin
            idx <= '0;
          end
        end
        DATA: begin
          if (tx_ready) begin
            csum <= csum ^ shadow[idx];
            idx  <= idx + 1'b1;
          end
        end
        CSUM: begin
          if (tx_ready) begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_state_streamer.sv
// Scoreboard bench for pin_state_streamer: expected bytes are queued at start and popped on every transfer.
module tb_pin_state_streamer;

  localparam int NB = 17;

  logic        CLK50 = 1'b0;
  logic        RST_N = 1'b1;
  logic        start = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  pins [0:NB-1];
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, dropped;
  logic [15:0] frame_cnt;

  logic        w_start = 1'b0;
  logic        w_ready = 1'b1;
  logic [7:0]  w_data;
  logic        w_valid, w_busy, w_done, w_dropped;
  logic [15:0] w_cnt;

  int          checks = 0;
  int          errors = 0;
  int          valid_cycles = 0;
  int          drop_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  pin_state_streamer dut (
    .CLK50(CLK50), .RST_N(RST_N), .start(start), .pin_state(pins),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .dropped(dropped), .frame_cnt(frame_cnt)
  );

  pin_state_streamer #(.FRAME_CNT_INIT(16'hFFFF)) u_wrap (
    .CLK50(CLK50), .RST_N(RST_N), .start(w_start), .pin_state(pins),
    .tx_data(w_data), .tx_valid(w_valid), .tx_ready(w_ready),
    .busy(w_busy), .done(w_done), .dropped(w_dropped), .frame_cnt(w_cnt)
  );

  always #10 CLK50 = ~CLK50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0x1FF can never match an 8-bit byte, so a transfer with nothing queued fails
  always @(negedge CLK50) begin
    if (tx_valid) valid_cycles++;
    if (dropped) drop_cnt++;
    if (done) done_cnt++;
    if (tx_valid && tx_ready) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h1FF;
      chk("byte", {24'h0, tx_data}, mon_exp);
    end
  end

  task automatic push_frame();
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(32'hA5);
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back({24'h0, pins[i]});
      x = x ^ pins[i];
    end
    exp_q.push_back({24'h0, x});
  endtask

  task automatic pulse_start();
    @(posedge CLK50); #1 start = 1'b1;
    @(posedge CLK50); #1 start = 1'b0;
    chk("lat_valid", {31'h0, tx_valid}, 32'h1);
    chk("lat_sync", {24'h0, tx_data}, 32'hA5);
  endtask

  task automatic wait_done(input logic [15:0] exp_cnt);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge CLK50);
      n++;
    end
    chk("done", {31'h0, done}, 32'h1);
    chk("frame_cnt", {16'h0, frame_cnt}, {16'h0, exp_cnt});
    chk("queue_empty", exp_q.size(), 0);
    @(negedge CLK50);
    chk("done_pulse", {31'h0, done}, 32'h0);
  endtask

  task automatic wait_q(input int remaining);
    int n;
    n = 0;
    while (exp_q.size() != remaining && n < 100) begin
      @(posedge CLK50); #1;
      n++;
    end
    chk("reach_pos", exp_q.size(), remaining);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int vc0, d0, dn0;
    for (int i = 0; i < NB; i++) pins[i] = 8'h00;
    #2 RST_N = 1'b0;
    #3;
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_dropped", {31'h0, dropped}, 32'h0);
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("rst_wcnt", {16'h0, w_cnt}, 32'hFFFF);
    repeat (3) @(negedge CLK50);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK50);
    #1 chk("idle_ready_ignored", {31'h0, busy}, 32'h0);

    // basic frame 01..11, must take 19 consecutive valid cycles
    for (int i = 0; i < NB; i++) pins[i] = 8'(i + 1);
    push_frame();
    vc0 = valid_cycles;
    d0  = drop_cnt;
    pulse_start();
    wait_done(16'd1);
    chk("valid_cycles", valid_cycles - vc0, 19);
    chk("no_drop", drop_cnt - d0, 0);

    // all-zero snapshot
    for (int i = 0; i < NB; i++) pins[i] = 8'h00;
    push_frame();
    pulse_start();
    wait_done(16'd2);

    // backpressure on byte 0x06 for three cycles
    for (int i = 0; i < NB; i++) pins[i] = 8'(i + 1);
    push_frame();
    pulse_start();
    wait_q(13);
    chk("bp_byte", {24'h0, tx_data}, 32'h06);
    tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK50);
      chk("bp_hold_data", {24'h0, tx_data}, 32'h06);
      chk("bp_hold_valid", {31'h0, tx_valid}, 32'h1);
      @(posedge CLK50); #1;
    end
    tx_ready = 1'b1;
    wait_done(16'd3);

    // snapshot isolation plus mid-frame drop
    for (int i = 0; i < NB; i++) pins[i] = 8'(8'h40 + i * 5);
    push_frame();
    d0 = drop_cnt;
    pulse_start();
    for (int i = 0; i < NB; i++) pins[i] = 8'hFF;
    repeat (5) @(posedge CLK50);
    #1 start = 1'b1;
    @(posedge CLK50); #1 start = 1'b0;
    wait_done(16'd4);
    chk("drop_once", drop_cnt - d0, 1);

    // start coinciding with the CSUM transfer is dropped too
    for (int i = 0; i < NB; i++) pins[i] = 8'(i * 3 + 7);
    push_frame();
    d0 = drop_cnt;
    pulse_start();
    wait_q(1);
    chk("csum_busy", {31'h0, busy}, 32'h1);
    start = 1'b1;
    @(posedge CLK50); #1 start = 1'b0;
    chk("csum_done", {31'h0, done}, 32'h1);
    chk("csum_cnt", {16'h0, frame_cnt}, 32'h5);
    repeat (3) @(posedge CLK50);
    #1 chk("csum_no_restart", {31'h0, busy}, 32'h0);
    chk("csum_drop", drop_cnt - d0, 1);
    chk("csum_q", exp_q.size(), 0);

    // reset while streaming data index 8
    for (int i = 0; i < NB; i++) pins[i] = 8'(i + 1);
    push_frame();
    pulse_start();
    wait_q(10);
    chk("idx8_data", {24'h0, tx_data}, 32'h09);
    #3 RST_N = 1'b0;
    #1;
    chk("arst_valid", {31'h0, tx_valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_data", {24'h0, tx_data}, 32'h0);
    chk("arst_cnt", {16'h0, frame_cnt}, 32'h0);
    exp_q.delete();
    dn0 = done_cnt;
    repeat (3) @(negedge CLK50);
    RST_N = 1'b1;
    chk("arst_no_done", done_cnt - dn0, 0);
    for (int i = 0; i < NB; i++) pins[i] = 8'(8'hC0 ^ i);
    push_frame();
    pulse_start();
    wait_done(16'd1);

    // frame counter wrap 0xFFFF -> 0x0000
    @(posedge CLK50); #1 w_start = 1'b1;
    @(posedge CLK50); #1 w_start = 1'b0;
    begin
      int n;
      n = 0;
      while (w_done !== 1'b1 && n < 200) begin
        @(negedge CLK50);
        n++;
      end
    end
    chk("wrap_done", {31'h0, w_done}, 32'h1);
    chk("wrap_cnt", {16'h0, w_cnt}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_state_streamer.md
PIN_STATE_STREAMER -- requirements
Module: pin_state_streamer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame header byte.
REQ-002 The block SHALL have parameter NUM_BYTES, default 17, the number of snapshot bytes per frame (0..NUM_BYTES-1).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port CLK50, input, 1: the single system clock; all state changes on its rising edge.
REQ-005 Port RST_N, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: one-cycle request to snapshot and stream pin_state.
REQ-007 Port pin_state, input, 8 x NUM_BYTES unpacked array [0:NUM_BYTES-1]: byte-packed pin state from the upstream pin-capture memory.
REQ-008 Port tx_data, output, 8: current stream byte.
REQ-009 Port tx_valid, output, 1: tx_data is valid.
REQ-010 Port tx_ready, input, 1: the downstream sink accepts the byte; a transfer occurs when tx_valid and tx_ready are both 1 on a rising edge.
REQ-011 Port busy, output, 1: high whenever the state is not IDLE.
REQ-012 Port done, output, 1: one-cycle pulse when a frame completes.
REQ-013 Port dropped, output, 1: one-cycle pulse when a start is rejected.
REQ-014 Port frame_cnt, output, 16: count of completed frames.

Function
REQ-015 The FSM SHALL have four states: IDLE, SYNC, DATA and CSUM.
REQ-016 In IDLE, start=1 at an edge SHALL do three things at that edge: copy all NUM_BYTES of pin_state into an internal shadow array, clear the checksum, and enter SYNC.
REQ-017 Changes on pin_state after the capture edge SHALL NOT affect the frame in progress.
REQ-018 In SYNC, tx_data SHALL equal SYNC_BYTE; on transfer the FSM SHALL enter DATA with byte index 0.
REQ-019 In DATA, tx_data SHALL equal shadow[index].
- On each transfer the checksum SHALL be updated to checksum XOR shadow[index] and the index SHALL increment.
- The transfer at index NUM_BYTES-1 SHALL enter CSUM.
REQ-020 In CSUM, tx_data SHALL equal the XOR of all NUM_BYTES data bytes; the sync byte is excluded.
REQ-021 On the CSUM transfer the FSM SHALL return to IDLE.
- At that edge, done SHALL be 1 for the following cycle.
- At that edge, frame_cnt SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-022 tx_valid SHALL be 1 in SYNC, DATA and CSUM, and 0 in IDLE.
REQ-023 While tx_valid=1 and tx_ready=0, tx_data and the state SHALL hold unchanged; there is no timeout.
REQ-024 Latency: start at edge k SHALL give tx_valid=1 with SYNC_BYTE in the cycle after edge k.
REQ-025 Frame throughput SHALL be NUM_BYTES+2 transfers; with tx_ready held at 1 this is 19 cycles for the default.
REQ-026 A start while busy=1 SHALL be ignored and SHALL produce dropped=1 for one cycle; this includes the cycle of the final CSUM transfer.
REQ-027 start in IDLE SHALL NOT pulse dropped.
REQ-028 tx_ready while in IDLE SHALL be ignored.

Reset
REQ-029 When RST_N=0, the block SHALL immediately and asynchronously set:
- state = IDLE;
- tx_valid, busy, done and dropped = 0;
- tx_data = 0x00, frame_cnt = 0x0000, index = 0, checksum = 0x00;
- shadow array = all 0x00.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse and no frame_cnt increment.
REQ-031 After the first rising edge with RST_N=1, the block SHALL accept start normally.

Verification
REQ-032 Basic frame:
- Stimulus: pin_state[i]=i+1 (0x01..0x11), start pulse, tx_ready=1.
- Required: bytes A5,01,02,...,11,01 on 19 consecutive cycles; done pulse; frame_cnt=1.
REQ-033 All-zero snapshot:
- Stimulus: pin_state all 0x00.
- Required: A5, seventeen 00 bytes, checksum 00.
REQ-034 Backpressure:
- Stimulus: pin_state[i]=i+1; tx_ready=0 for 3 cycles while tx_data=0x06.
- Required: tx_data holds 0x06 with tx_valid=1 for the 3 cycles; the remaining stream is unchanged; checksum 0x01.
REQ-035 Snapshot isolation and drop:
- Stimulus: set pin_state to all 0xFF one cycle after start, and pulse start again mid-frame.
- Required: the frame carries the original bytes; dropped pulses once; frame_cnt increments by 1 only.
REQ-036 Reset mid-frame:
- Stimulus: RST_N=0 during DATA at index 8.
- Required: tx_valid=0 immediately; no done; frame_cnt=0; a new start yields a full correct frame.
REQ-037 Counter wrap:
- Stimulus: frame_cnt preloaded or advanced to 0xFFFF; one more frame completes.
- Required: frame_cnt=0x0000 together with the done pulse.
